wb_xbar_wrapper: RTL and testbench

- Multi-host, multi-device crossbar for the system bus; sits between CPU-side masters (instruction/data ports, debug) and memory-mapped peripherals (RAM, GPIO, PWM, UART, timer, SPI, sim-ctrl, Wishbone bridge, debug).
- Decodes each host address against per-device base/mask windows, arbitrates concurrent hosts per device, forwards req/gnt requests and routes rvalid/rdata/err responses back to the issuing host.
- One outstanding transaction per host and per device.

---
 rtl/wb_xbar_wrapper.sv | 190 +++++++++++++++++++
 tb/tb_wb_xbar_wrapper.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_xbar_wrapper.sv
// Multi-host / multi-device request-grant crossbar: address-window decode, fixed-priority
// arbitration per device, one outstanding transaction per host and device.
// Optional build macro WBXBAR_TIMEOUT_EN: a silent device gets an error response after 255 busy cycles.
module wb_xbar_wrapper #(
  parameter int NrDevices    = 9,
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter logic [NrDevices*AddressWidth-1:0] SLAVE_ADDR = '0,
  parameter logic [NrDevices*AddressWidth-1:0] SLAVE_MASK = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    host_req_i     [NrHosts],
  output logic                    host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i    [NrHosts],
  input  logic                    host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i   [NrHosts],
  output logic                    host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o   [NrHosts],
  output logic                    host_err_o     [NrHosts],
  output logic                    device_req_o   [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic                    device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic                    device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
  input  logic                    device_err_i   [NrDevices]
);

  localparam int HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [NrHosts-1:0]   host_busy_q, host_busy_d;
  logic [NrHosts-1:0]   derr_q, derr_d;
  logic [NrDevices-1:0] dev_busy_q, dev_busy_d;
  logic [HW-1:0]        owner_q [NrDevices];
  logic [HW-1:0]        owner_d [NrDevices];
  logic [NrDevices-1:0] tmo;
  logic [NrDevices-1:0] dev_done;
  logic [NrDevices-1:0] claim;
  logic                 hit [NrHosts];
  logic [DW-1:0]        tgt [NrHosts];

`ifdef WBXBAR_TIMEOUT_EN
  logic [7:0] cnt_q [NrDevices];
  logic [7:0] cnt_d [NrDevices];
`endif

  // Scan from the top so the lowest matching device index is the one left standing.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      hit[h] = 1'b0;
      tgt[h] = '0;
      for (int d = NrDevices - 1; d >= 0; d--) begin
        if ((host_addr_i[h] & SLAVE_MASK[d*AddressWidth +: AddressWidth]) ==
            (SLAVE_ADDR[d*AddressWidth +: AddressWidth] & SLAVE_MASK[d*AddressWidth +: AddressWidth])) begin
          hit[h] = 1'b1;
          tgt[h] = DW'(d);
        end
      end
    end
  end

  always_comb begin
    claim = '0;
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = 1'b0;
      if (rst_ni && host_req_i[h] && !host_busy_q[h]) begin
        if (!hit[h]) begin
          host_gnt_o[h] = 1'b1;
        end else if (!dev_busy_q[tgt[h]] && !claim[tgt[h]]) begin
          host_gnt_o[h]    = 1'b1;
          claim[tgt[h]]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = '0;
      device_we_o[d]    = 1'b0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
      for (int h = 0; h < NrHosts; h++) begin
        if (host_gnt_o[h] && hit[h] && tgt[h] == DW'(d)) begin
          device_req_o[d]   = 1'b1;
          device_addr_o[d]  = host_addr_i[h];
          device_we_o[d]    = host_we_i[h];
          device_be_o[d]    = host_be_i[h];
          device_wdata_o[d] = host_wdata_i[h];
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
`ifdef WBXBAR_TIMEOUT_EN
      tmo[d] = (cnt_q[d] == 8'hFF);
`else
      tmo[d] = 1'b0;
`endif
      dev_done[d] = dev_busy_q[d] && (device_rvalid_i[d] || tmo[d]);
    end
  end

  // Responses only count while the device is busy, so stray or post-reset rvalids fall away.
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = derr_q[h];
      host_err_o[h]    = derr_q[h];
      host_rdata_o[h]  = '0;
      for (int d = 0; d < NrDevices; d++) begin
        if (dev_busy_q[d] && owner_q[d] == HW'(h)) begin
          if (device_rvalid_i[d]) begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = device_err_i[d];
            host_rdata_o[h]  = device_rdata_i[d];
          end else if (tmo[d]) begin
            host_rvalid_o[h] = 1'b1;
            host_err_o[h]    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    host_busy_d = host_busy_q;
    dev_busy_d  = dev_busy_q;
    derr_d      = '0;
    for (int d = 0; d < NrDevices; d++) begin
      owner_d[d] = owner_q[d];
      if (dev_done[d]) dev_busy_d[d] = 1'b0;
    end
    for (int h = 0; h < NrHosts; h++) begin
      if (host_rvalid_o[h]) host_busy_d[h] = 1'b0;
      if (host_gnt_o[h]) begin
        host_busy_d[h] = 1'b1;
        if (hit[h]) begin
          dev_busy_d[tgt[h]] = 1'b1;
          owner_d[tgt[h]]    = HW'(h);
        end else begin
          derr_d[h] = 1'b1;
        end
      end
    end
  end

`ifdef WBXBAR_TIMEOUT_EN
  // Loaded with 1 on grant so the value equals the number of busy cycles seen so far.
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      if (device_req_o[d])                    cnt_d[d] = 8'd1;
      else if (dev_busy_q[d] && !dev_done[d]) cnt_d[d] = cnt_q[d] + 8'd1;
      else                                    cnt_d[d] = 8'd0;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      host_busy_q <= '0;
      dev_busy_q  <= '0;
      derr_q      <= '0;
      for (int d = 0; d < NrDevices; d++) begin
        owner_q[d] <= '0;
`ifdef WBXBAR_TIMEOUT_EN
        cnt_q[d]   <= '0;
`endif
      end
    end else begin
      host_busy_q <= host_busy_d;
      dev_busy_q  <= dev_busy_d;
      derr_q      <= derr_d;
      for (int d = 0; d < NrDevices; d++) begin
        owner_q[d] <= owner_d[d];
`ifdef WBXBAR_TIMEOUT_EN
        cnt_q[d]   <= cnt_d[d];
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_xbar_wrapper.sv
// Bench for wb_xbar_wrapper: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (outstanding transaction per host, address ranges).
module tb_wb_xbar_wrapper;
  localparam int NH = 2;
  localparam int ND = 9;

  int unsigned base_t [ND] = '{32'h0010_0000, 32'h8000_0000, 32'h8000_2000, 32'h8000_1000,
                               32'h8000_3000, 32'h8000_4000, 32'h0002_0000, 32'h8000_5000,
                               32'h1a11_0000};
  int unsigned size_t [ND] = '{32'h2_0000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000,
                               32'h400, 32'h1000, 32'h8000};

  logic clk = 1'b0;
  logic rst_n;
  logic        h_req [NH], h_gnt [NH], h_we [NH], h_rv [NH], h_err [NH];
  logic [31:0] h_addr [NH], h_wdata [NH], h_rdata [NH];
  logic [3:0]  h_be [NH];
  logic        d_req [ND], d_we [ND], d_rv [ND], d_err [ND];
  logic [31:0] d_addr [ND], d_wdata [ND], d_rdata [ND];
  logic [3:0]  d_be [ND];

  int out_dev [NH];  // -2 idle, -1 decode error pending, else device index
  int out_age [NH];  // busy cycles since grant, 1 in the first cycle after grant
  int nvec = 0;
  int nerr = 0;

  wb_xbar_wrapper #(
    .NrDevices(ND), .NrHosts(NH), .DataWidth(32), .AddressWidth(32),
    .SLAVE_ADDR({32'h1a11_0000, 32'h8000_5000, 32'h0002_0000, 32'h8000_4000, 32'h8000_3000,
                 32'h8000_1000, 32'h8000_2000, 32'h8000_0000, 32'h0010_0000}),
    .SLAVE_MASK({32'hFFFF_8000, 32'hFFFF_F000, 32'hFFFF_FC00, 32'hFFFF_F000, 32'hFFFF_F000,
                 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFE_0000})
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(h_req), .host_gnt_o(h_gnt), .host_addr_i(h_addr), .host_we_i(h_we),
    .host_be_i(h_be), .host_wdata_i(h_wdata), .host_rvalid_o(h_rv), .host_rdata_o(h_rdata),
    .host_err_o(h_err),
    .device_req_o(d_req), .device_addr_o(d_addr), .device_we_o(d_we), .device_be_o(d_be),
    .device_wdata_o(d_wdata), .device_rvalid_i(d_rv), .device_rdata_i(d_rdata),
    .device_err_i(d_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int d = 0; d < ND; d++)
      if (longint'(a) >= longint'(base_t[d]) && longint'(a) < longint'(base_t[d]) + longint'(size_t[d]))
        return d;
    return -1;
  endfunction

  function automatic bit dev_owned(input int d);
    for (int h = 0; h < NH; h++) if (out_dev[h] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle_in();
    for (int h = 0; h < NH; h++) begin
      h_req[h] = 0; h_addr[h] = 0; h_we[h] = 0; h_be[h] = 0; h_wdata[h] = 0;
    end
    for (int d = 0; d < ND; d++) begin
      d_rv[d] = 0; d_rdata[d] = 0; d_err[d] = 0;
    end
  endtask

  // One clock: predict and compare at negedge, then advance the model at posedge.
  task automatic step();
    bit eg [NH]; bit er [NH]; bit ee [NH]; logic [31:0] erd [NH]; int tg [NH];
    bit claimed [ND];
    bit ereq; logic [31:0] ea, ew; logic [3:0] eb; logic ewe;
    @(negedge clk);
    for (int d = 0; d < ND; d++) claimed[d] = 0;
    for (int h = 0; h < NH; h++) begin
      eg[h] = 0; er[h] = 0; ee[h] = 0; erd[h] = 0; tg[h] = decode(h_addr[h]);
      if (rst_n) begin
        if (out_dev[h] == -1) begin
          er[h] = 1; ee[h] = 1;
        end else if (out_dev[h] >= 0) begin
          if (d_rv[out_dev[h]]) begin
            er[h] = 1; ee[h] = d_err[out_dev[h]]; erd[h] = d_rdata[out_dev[h]];
          end
`ifdef WBXBAR_TIMEOUT_EN
          else if (out_age[h] == 255) begin
            er[h] = 1; ee[h] = 1;
          end
`endif
        end else if (h_req[h]) begin
          if (tg[h] < 0) eg[h] = 1;
          else if (!dev_owned(tg[h]) && !claimed[tg[h]]) begin
            eg[h] = 1; claimed[tg[h]] = 1;
          end
        end
      end
      chk($sformatf("gnt%0d", h), h_gnt[h], eg[h]);
      chk($sformatf("rvalid%0d", h), h_rv[h], er[h]);
      chk($sformatf("err%0d", h), h_err[h], ee[h]);
      chk($sformatf("rdata%0d", h), h_rdata[h], erd[h]);
    end
    for (int d = 0; d < ND; d++) begin
      ereq = 0; ea = 0; ew = 0; eb = 0; ewe = 0;
      for (int h = 0; h < NH; h++)
        if (eg[h] && tg[h] == d) begin
          ereq = 1; ea = h_addr[h]; ew = h_wdata[h]; eb = h_be[h]; ewe = h_we[h];
        end
      chk($sformatf("dreq%0d", d), d_req[d], ereq);
      chk($sformatf("daddr%0d", d), d_addr[d], ea);
      chk($sformatf("dwe%0d", d), d_we[d], ewe);
      chk($sformatf("dbe%0d", d), d_be[d], eb);
      chk($sformatf("dwdata%0d", d), d_wdata[d], ew);
    end
    @(posedge clk);
    for (int h = 0; h < NH; h++) begin
      if (!rst_n || er[h]) out_dev[h] = -2;
      else if (out_dev[h] >= 0) out_age[h]++;
      if (rst_n && eg[h]) begin
        out_dev[h] = tg[h]; out_age[h] = 1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    int d;
    case ($urandom % 12)
      0: return 32'h0012_0000;
      1: return 32'h000F_FFFC;
      2: return 32'h8000_6000;
      3: return $urandom;
      default: begin
        d = $urandom % ND;
        if ($urandom % 4 == 0) return base_t[d] + size_t[d] - 4;
        return base_t[d] + (($urandom % size_t[d]) & ~32'h3);
      end
    endcase
  endfunction

  initial begin
    for (int h = 0; h < NH; h++) begin out_dev[h] = -2; out_age[h] = 0; end
    idle_in();
    rst_n = 0;
    h_req[1] = 1; h_addr[1] = 32'h0010_0000; h_be[1] = 4'hF;
    #1;
    chk("rst_gnt1", h_gnt[1], 0);
    chk("rst_dreq0", d_req[0], 0);
    step(); step();
    rst_n = 1;

    // RAM read from host 1, response two cycles after grant
    idle_in();
    h_req[1] = 1; h_addr[1] = 32'h0010_0000; h_be[1] = 4'hF; h_wdata[1] = 32'h0bad_beef;
    #1;
    chk("ram_gnt1", h_gnt[1], 1);
    chk("ram_dreq0", d_req[0], 1);
    chk("ram_daddr0", d_addr[0], 32'h0010_0000);
    step();
    idle_in(); step();
    d_rv[0] = 1; d_rdata[0] = 32'h1234_5678;
    #1;
    chk("ram_rv1", h_rv[1], 1);
    chk("ram_rdata1", h_rdata[1], 32'h1234_5678);
    chk("ram_err1", h_err[1], 0);
    step();

    // Decode: UART, debug, past end of RAM
    idle_in(); h_req[0] = 1; h_we[0] = 1; h_addr[0] = 32'h8000_1004; h_be[0] = 4'h3;
    #1 chk("dec_uart", d_req[3], 1);
    step();
    idle_in(); d_rv[3] = 1; step();
    idle_in(); h_req[0] = 1; h_addr[0] = 32'h1a11_0000;
    #1 chk("dec_dbg", d_req[8], 1);
    step();
    idle_in(); d_rv[8] = 1; step();
    idle_in(); h_req[0] = 1; h_addr[0] = 32'h0012_0000;
    #1 chk("dec_err_gnt", h_gnt[0], 1);
    step();
    idle_in();
    #1 chk("dec_err_rv", h_rv[0], 1);
    chk("dec_err_err", h_err[0], 1);
    step();

    // Contention on GPIO; host 1 waits until the cycle after the response
    idle_in();
    h_req[0] = 1; h_addr[0] = 32'h8000_0000; h_req[1] = 1; h_addr[1] = 32'h8000_0000; h_we[1] = 1;
    #1 chk("cont_gnt0", h_gnt[0], 1);
    chk("cont_gnt1", h_gnt[1], 0);
    step();
    h_req[0] = 0;
    #1 chk("cont_wait1", h_gnt[1], 0);
    step();
    d_rv[1] = 1; d_rdata[1] = 32'h5555_aaaa;
    #1 chk("cont_rv0", h_rv[0], 1);
    chk("cont_same_cyc", h_gnt[1], 0);
    step();
    d_rv[1] = 0;
    #1 chk("cont_gnt1_late", h_gnt[1], 1);
    step();
    idle_in(); d_rv[1] = 1; step();

    // Parallel grants, out-of-order responses with device error
    idle_in();
    h_req[0] = 1; h_addr[0] = 32'h8000_0010; h_req[1] = 1; h_addr[1] = 32'h0010_0040;
    #1 chk("par_gnt0", h_gnt[0], 1);
    chk("par_gnt1", h_gnt[1], 1);
    step();
    idle_in(); d_rv[0] = 1; d_err[0] = 1; d_rdata[0] = 32'h0000_00ee;
    #1 chk("par_err1", h_err[1], 1);
    chk("par_rv0_quiet", h_rv[0], 0);
    step();
    idle_in(); d_rv[1] = 1; d_rdata[1] = 32'hcafe_f00d;
    #1 chk("par_rdata0", h_rdata[0], 32'hcafe_f00d);
    step();
    idle_in(); step();

`ifdef WBXBAR_TIMEOUT_EN
    h_req[0] = 1; h_addr[0] = 32'h8000_4000;
    step();
    for (int i = 0; i < 260; i++) begin
      idle_in();
      if (i == 258) d_rv[5] = 1;
      step();
    end
    idle_in(); h_req[1] = 1; h_addr[1] = 32'h8000_4008;
    #1 chk("tmo_reuse", h_gnt[1], 1);
    step();
    idle_in(); d_rv[5] = 1; step();
`endif

    // Random traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) rst_n = 0;
      if (i == 702) rst_n = 1;
      for (int h = 0; h < NH; h++) begin
        h_req[h] = ($urandom % 3) != 0; h_addr[h] = pick_addr(); h_we[h] = $urandom;
        h_be[h] = $urandom; h_wdata[h] = $urandom;
      end
      for (int d = 0; d < ND; d++) begin
        d_rv[d] = dev_owned(d) ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
        d_rdata[d] = $urandom; d_err[d] = ($urandom % 4) == 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
